// File: rtl/pc_redirect.sv
// pc_redirect: fetch-address generator for a MIPS-style front end.
// Advances the fetch PC by 4 each unstalled cycle and redirects it for
// jumps, register jumps and conditional branches. A register jump whose
// operand is not ready, and every branch, park the block in a wait state
// until the operand or the branch outcome arrives. Each redirect produces
// a one-cycle flush pulse that kills the wrong-path instruction in fetch.
module pc_redirect (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        dec_valid,
    input  logic [31:0] cmd,
    input  logic [31:0] pc_dec,
    input  logic        isJmp,
    input  logic        isJr,
    input  logic        isBr,
    input  logic [31:0] rs_val,
    input  logic        rs_valid,
    input  logic        br_valid,
    input  logic        br_taken,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        flush,
    output logic        busy
);

    // 2'b11 is deliberately left out of the enum; it decodes back to RUN.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT_JR = 2'b01,
        WAIT_BR = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        flush_q, flush_d;

    logic [31:0] p4;
    logic [31:0] jmp_tgt;
    logic [31:0] br_tgt;
    logic [31:0] reg_tgt;
    logic        accept;

    // Opcode bits and the low bits of rs never steer a target.
    logic unused_bits;
    assign unused_bits = ^{cmd[31:26], rs_val[1:0]};

    // Candidate redirect targets, computed every cycle from the decode slot.
    assign p4      = pc_dec + 32'd4;
    assign jmp_tgt = {p4[31:28], cmd[25:0], 2'b00};
    assign br_tgt  = p4 + {{14{cmd[15]}}, cmd[15:0], 2'b00};
    assign reg_tgt = {rs_val[31:2], 2'b00};

    assign accept  = (state_q == RUN) && dec_valid && !stall;

    // Next-state logic: sequential PC, redirects and the two wait states.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        flush_d = 1'b0;

        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (accept && isJr) begin
                        if (rs_valid) begin
                            pc_d    = reg_tgt;
                            flush_d = 1'b1;
                        end else begin
                            state_d = WAIT_JR;
                        end
                    end else if (accept && isJmp) begin
                        pc_d    = jmp_tgt;
                        flush_d = 1'b1;
                    end else if (accept && isBr) begin
                        // The outcome is never consumed in the accept cycle.
                        tgt_d   = br_tgt;
                        state_d = WAIT_BR;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                WAIT_JR: begin
                    if (rs_valid) begin
                        pc_d    = reg_tgt;
                        flush_d = 1'b1;
                        state_d = RUN;
                    end
                end
                WAIT_BR: begin
                    if (br_valid) begin
                        if (br_taken) begin
                            pc_d    = tgt_q;
                            flush_d = 1'b1;
                        end
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end else if (state_q != RUN && state_q != WAIT_JR && state_q != WAIT_BR) begin
            // The spare encoding recovers even while stalled.
            state_d = RUN;
        end
    end

    // State, PC, captured branch target and flush pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= 32'h0000_0000;
            tgt_q   <= 32'h0000_0000;
            flush_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of order.
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
        end
    end

    assign pc       = pc_q;
    assign flush    = flush_q;
    assign busy     = (state_q != RUN);
    assign fetch_en = (state_q == RUN) && !stall && !reset;

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  clock, rising edge.
- reset  in  1  async active-high reset.
- stall  in  1  external hazard stall; freezes the block.
- dec_valid  in  1  decode-stage instruction valid.
- cmd  in  32  instruction word in decode.
- pc_dec  in  32  address of the instruction in decode.
- isJmp  in  1  decoder flag: unconditional jump (j or jr).
- isJr  in  1  decoder flag: register jump.
- isBr  in  1  decoder flag: conditional branch.
- rs_val  in  32  rs operand for jr.
- rs_valid  in  1  rs_val is hazard-free this cycle.
- br_valid  in  1  branch outcome available this cycle.
- br_taken  in  1  branch outcome, qualified by br_valid.
- pc  out  32  fetch address, registered.
- fetch_en  out  1  fetch at pc this cycle.
- flush  out  1  kill the wrong-path instruction in fetch; registered 1-cycle pulse.
- busy  out  1  high when state is not RUN.

Function
REQ-003 The block SHALL implement the states RUN, WAIT_JR and WAIT_BR, encoded in 2 bits; the spare encoding SHALL go to RUN.
REQ-004 The block SHALL compute fetch_en = (state==RUN) & !stall & !reset, combinationally.
REQ-005 A decode SHALL be accepted when state==RUN & dec_valid & !stall; the flag precedence is isJr, then isJmp, then isBr.
REQ-006 The block SHALL compute the targets as follows, with all arithmetic mod 2^32 and wrap permitted:
- p4 = pc_dec+4.
- jump target jt = {p4[31:28], cmd[25:0], 2'b00}.
- branch target bt = p4 + (sign-extended cmd[15:0] << 2).
- register target = {rs_val[31:2], 2'b00}.
REQ-007 In RUN with no accepted flow instruction and fetch_en=1, the block SHALL set pc <= pc+4; 0xFFFFFFFC SHALL wrap to 0x00000000.
REQ-008 On an accepted isJmp & !isJr, the block SHALL set pc <= jt and flush <= 1 on the next edge, staying in RUN (1-cycle redirect latency).
REQ-009 On an accepted isJr with rs_valid=1, the block SHALL set pc <= register target and flush <= 1, staying in RUN.
REQ-010 On an accepted isJr with rs_valid=0, the block SHALL enter WAIT_JR and hold pc.
REQ-011 In WAIT_JR with rs_valid=1 and !stall, the block SHALL set pc <= register target, flush <= 1, and return to RUN.
REQ-012 On an accepted isBr, the block SHALL register bt into an internal target register, enter WAIT_BR, and hold pc.
REQ-013 In WAIT_BR with br_valid=1 and !stall:
- taken: pc <= captured bt, flush <= 1.
- not taken: pc unchanged, flush stays 0.
- both cases: return to RUN.
REQ-014 The block SHALL ignore br_valid and rs_valid while in RUN; a branch outcome arriving in the same cycle as isBr acceptance SHALL NOT be consumed.
REQ-015 In WAIT_JR and WAIT_BR the block SHALL ignore dec_valid; the decode stage holds its instruction while busy=1.
REQ-016 While stall=1 the block SHALL freeze pc, state and the captured target, and drive flush=0 on the next edge; upstream holds rs_valid/br_valid until consumed.
REQ-017 flush SHALL be high for exactly one cycle per redirect; back-to-back redirects SHALL produce back-to-back pulses.
REQ-018 The block SHALL drive busy = (state != RUN), combinationally.

Reset
REQ-019 While reset=1, independent of clk, the block SHALL force:
- pc=0x00000000.
- state=RUN.
- flush=0.
- captured target=0.
- fetch_en=0.
REQ-020 Reset asserted in WAIT_JR or WAIT_BR SHALL abandon the pending redirect; after release the block SHALL fetch from 0x00000000 with no flush.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Release reset, no decode, 3 cycles -> pc = 0,4,8,0xC; flush=0.
- pc_dec=0x00400010, j with cmd[25:0]=0x0100020 -> next pc=0x00400080, flush=1 for one cycle.
- jr with rs_val=0x12345677, rs_valid=0 for 2 cycles then 1 -> busy=1 and fetch_en=0 for 2 cycles, then pc=0x12345674, flush pulse.
- beq at pc_dec=0x100, imm=0xFFFE, br_valid after 3 cycles, taken -> pc=0x000000FC, flush=1; repeat not-taken -> pc unchanged, flush=0.
- Reset asserted mid-WAIT_BR, then br_valid=1 after release -> pc=0 sequence, no flush.
- pc=0xFFFFFFFC, no flow instruction -> next pc=0x00000000.
